serdesphy_rx_deser: RTL and testbench

Digital RX deserializer and word aligner on the receive side of the SerDes PHY. It sits between the PMA recovered serial bit (one bit per `clk_240m_rx` cycle) and the RX PCS. It hunts for a framing sync word and locks to the word boundary after repeated confirmation. While locked it emits parallel data words, and it drops lock after consecutive missed sync slots. It is the receive counterpart of the TX serializer framing, which sends one sync word per frame.

---
 rtl/serdesphy_pkg.sv | 23 ++
 rtl/serdesphy_rx_deser_if.sv | 35 +++
 rtl/serdesphy_rx_lock_fsm.sv | 121 ++++++++++++
 rtl/serdesphy_rx_deser.sv | 122 ++++++++++++
 tb/tb_serdesphy_rx_deser.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serdesphy_pkg.sv
// ============================================================
// serdesphy_pkg : shared SerDes PHY types and framing constants
// Rev 1.0
// ============================================================
`default_nettype none

package serdesphy_pkg;

  typedef enum logic [1:0] {
    DESER_IDLE   = 2'd0,
    DESER_HUNT   = 2'd1,
    DESER_VERIFY = 2'd2,
    DESER_LOCKED = 2'd3
  } deser_state_t;

  // Framing shared with the TX framer
  localparam int unsigned SERDES_WORD_W    = 16;
  localparam int unsigned SERDES_FRAME_LEN = 8;
  localparam logic [15:0] SERDES_SYNC_WORD = 16'hA5C3;

endpackage

`default_nettype wire

// File: rtl/serdesphy_rx_deser_if.sv
// ============================================================
// serdesphy_rx_deser_if : serial-in / parallel-out RX bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface serdesphy_rx_deser_if
  import serdesphy_pkg::*;
#(
  parameter int unsigned WORD_W = SERDES_WORD_W
);

  logic              deser_enable;
  logic              serial_data;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              deser_lock;
  logic              deser_active;
  logic              deser_error;
  logic [7:0]        sync_err_cnt;

  // master: PMA/PCS side driving the bit stream and consuming words
  modport master (
    output deser_enable, serial_data,
    input  rx_data, rx_valid, deser_lock, deser_active, deser_error, sync_err_cnt
  );

  modport slave (
    input  deser_enable, serial_data,
    output rx_data, rx_valid, deser_lock, deser_active, deser_error, sync_err_cnt
  );

endinterface

`default_nettype wire

// File: rtl/serdesphy_rx_lock_fsm.sv
// ============================================================
// serdesphy_rx_lock_fsm : hunt/verify/lock state machine
// Rev 1.0
// ============================================================
`default_nettype none

module serdesphy_rx_lock_fsm
  import serdesphy_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned MISS_MAX = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         boundary,
  input  logic         slot0,
  input  logic         sync_match,
  output deser_state_t state,
  output logic         realign,
  output logic         miss_event,
  output logic         deser_lock,
  output logic         deser_error
);

  localparam int unsigned GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

  deser_state_t      state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              lock_q, lock_d;
  logic              error_q, error_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DESER_IDLE;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      lock_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      lock_q     <= lock_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    realign    = 1'b0;
    miss_event = 1'b0;

    case (state_q)
      DESER_IDLE: state_d = DESER_HUNT;

      DESER_HUNT: begin
        if (sync_match) begin
          realign    = 1'b1;
          good_cnt_d = GOOD_W'(1);
          state_d    = (LOCK_CNT == 1) ? DESER_LOCKED : DESER_VERIFY;
        end
      end

      DESER_VERIFY: begin
        if (boundary && slot0) begin
          if (sync_match) begin
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
              state_d = DESER_LOCKED;
            end
          end else begin
            good_cnt_d = '0;
            state_d    = DESER_HUNT;
          end
        end
      end

      DESER_LOCKED: begin
        if (boundary && slot0) begin
          if (sync_match) begin
            miss_cnt_d = '0;
          end else begin
            miss_event = 1'b1;
            miss_cnt_d = miss_cnt_q + 1'b1;
            if (miss_cnt_q == MISS_W'(MISS_MAX - 1)) begin
              miss_cnt_d = '0;
              good_cnt_d = '0;
              state_d    = DESER_HUNT;
            end
          end
        end
      end

      default: state_d = DESER_IDLE;
    endcase

    // Disable wins over any lock, miss or realign decided above
    if (!enable) begin
      state_d    = DESER_IDLE;
      good_cnt_d = '0;
      miss_cnt_d = '0;
      realign    = 1'b0;
      miss_event = 1'b0;
    end

    lock_d  = (state_d == DESER_LOCKED);
    error_d = miss_event;
  end

  assign state       = state_q;
  assign deser_lock  = lock_q;
  assign deser_error = error_q;

endmodule

`default_nettype wire

// File: rtl/serdesphy_rx_deser.sv
// ============================================================
// serdesphy_rx_deser : RX deserializer and sync-word aligner
// Rev 1.0
// ============================================================
`default_nettype none

module serdesphy_rx_deser
  import serdesphy_pkg::*;
#(
  parameter int unsigned       WORD_W    = SERDES_WORD_W,
  parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(SERDES_SYNC_WORD),
  parameter int unsigned       FRAME_LEN = SERDES_FRAME_LEN,
  parameter int unsigned       LOCK_CNT  = 3,
  parameter int unsigned       MISS_MAX  = 2
) (
  input  logic               clk_240m_rx,
  input  logic               rst,
  serdesphy_rx_deser_if.slave rx_if
);

  localparam int unsigned BIT_CNT_W = $clog2(WORD_W);
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  logic [WORD_W-1:0]    sr_q, sr_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  logic [WORD_W-1:0]    rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 active_q, active_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  deser_state_t fsm_state;
  logic         realign;
  logic         miss_event;
  logic         boundary;
  logic         slot0;
  logic         sync_match;
  logic         running;

  assign running    = rx_if.deser_enable && (fsm_state != DESER_IDLE);
  assign boundary   = (bit_cnt_q == BIT_CNT_W'(WORD_W - 1));
  // word_idx names the last consumed slot, so slot 0 completes when it sits at the end
  assign slot0      = (word_idx_q == IDX_W'(FRAME_LEN - 1));
  assign sync_match = (sr_q == SYNC_WORD);

  serdesphy_rx_lock_fsm #(
    .LOCK_CNT (LOCK_CNT),
    .MISS_MAX (MISS_MAX)
  ) u_lock_fsm (
    .clk         (clk_240m_rx),
    .rst         (rst),
    .enable      (rx_if.deser_enable),
    .boundary    (boundary),
    .slot0       (slot0),
    .sync_match  (sync_match),
    .state       (fsm_state),
    .realign     (realign),
    .miss_event  (miss_event),
    .deser_lock  (rx_if.deser_lock),
    .deser_error (rx_if.deser_error)
  );

  always_comb begin
    sr_d       = '0;
    bit_cnt_d  = '0;
    word_idx_d = '0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    err_cnt_d  = err_cnt_q;
    active_d   = running;

    if (running) begin
      sr_d = {sr_q[WORD_W-2:0], rx_if.serial_data};
      if (realign) begin
        bit_cnt_d  = '0;
        word_idx_d = '0;
      end else if (boundary) begin
        bit_cnt_d  = '0;
        word_idx_d = slot0 ? '0 : word_idx_q + 1'b1;
      end else begin
        bit_cnt_d  = bit_cnt_q + 1'b1;
        word_idx_d = word_idx_q;
      end
      rx_valid_d = (fsm_state == DESER_LOCKED) && boundary && !slot0;
    end

    if (rx_valid_d) begin
      rx_data_d = sr_q;
    end
    if (miss_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_240m_rx) begin
    if (rst) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      active_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      active_q   <= active_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rx_if.rx_data      = rx_data_q;
  assign rx_if.rx_valid     = rx_valid_q;
  assign rx_if.deser_active = active_q;
  assign rx_if.sync_err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_serdesphy_rx_deser.sv
// ============================================================
// tb_serdesphy_rx_deser : random-stimulus bench with frame-level reference model
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serdesphy_rx_deser;

  localparam int WORD_W    = 16;
  localparam int FRAME_LEN = 8;
  localparam int LOCK_CNT  = 3;
  localparam int MISS_MAX  = 2;
  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam logic [15:0] BAD  = 16'hA5C2;

  localparam int M_IDLE   = 0;
  localparam int M_HUNT   = 1;
  localparam int M_VERIFY = 2;
  localparam int M_LOCKED = 3;

  logic clk_240m_rx = 1'b0;
  logic rst = 1'b1;

  serdesphy_rx_deser_if #(.WORD_W(WORD_W)) rx_if ();

  serdesphy_rx_deser #(
    .WORD_W    (WORD_W),
    .SYNC_WORD (SYNC),
    .FRAME_LEN (FRAME_LEN),
    .LOCK_CNT  (LOCK_CNT),
    .MISS_MAX  (MISS_MAX)
  ) dut (
    .clk_240m_rx (clk_240m_rx),
    .rst         (rst),
    .rx_if       (rx_if.slave)
  );

  always #2 clk_240m_rx = ~clk_240m_rx;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: alignment tracked as a bit count since the last sync hit
  int          m_mode   = M_IDLE;
  logic [15:0] m_win    = '0;
  int          m_since  = 0;
  int          m_goods  = 0;
  int          m_misses = 0;
  logic [15:0] m_data   = '0;
  bit          m_valid  = 1'b0;
  bit          m_lock   = 1'b0;
  bit          m_active = 1'b0;
  bit          m_err    = 1'b0;
  int          m_errcnt = 0;

  int          n_valid     = 0;
  int          n_err_pulse = 0;
  bit          seen_valid  = 1'b0;
  logic [15:0] first_valid = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit b);
    bit complete;
    bit match;
    int slot;
    int nmode;
    if (r) begin
      m_mode = M_IDLE; m_win = '0; m_since = 0; m_goods = 0; m_misses = 0;
      m_data = '0; m_valid = 0; m_lock = 0; m_active = 0; m_err = 0; m_errcnt = 0;
      return;
    end
    m_valid = 0;
    m_err   = 0;
    if (!en) begin
      m_mode = M_IDLE; m_win = '0; m_since = 0; m_goods = 0; m_misses = 0;
      m_lock = 0; m_active = 0;
      return;
    end
    m_active = (m_mode != M_IDLE);
    match    = (m_win == SYNC);
    complete = (m_since > 0) && (m_since % WORD_W == 0);
    slot     = (m_since / WORD_W) % FRAME_LEN;
    nmode    = m_mode;
    case (m_mode)
      M_IDLE: nmode = M_HUNT;
      M_HUNT: begin
        if (match) begin
          m_goods = 1;
          m_since = 0;
          nmode   = (LOCK_CNT == 1) ? M_LOCKED : M_VERIFY;
        end
      end
      M_VERIFY: begin
        if (complete && slot == 0) begin
          if (match) begin
            m_goods++;
            if (m_goods == LOCK_CNT) nmode = M_LOCKED;
          end else begin
            m_goods = 0;
            nmode   = M_HUNT;
          end
        end
      end
      default: begin
        if (complete) begin
          if (slot != 0) begin
            m_valid = 1;
            m_data  = m_win;
          end else if (match) begin
            m_misses = 0;
          end else begin
            m_misses++;
            m_err = 1;
            if (m_errcnt < 255) m_errcnt++;
            if (m_misses == MISS_MAX) begin
              nmode    = M_HUNT;
              m_misses = 0;
              m_goods  = 0;
            end
          end
        end
      end
    endcase
    if (m_mode != M_IDLE) begin
      m_win = {m_win[14:0], b};
      m_since++;
    end
    m_mode = nmode;
    m_lock = (m_mode == M_LOCKED);
  endtask

  task automatic send_bit(input bit en, input bit b);
    @(negedge clk_240m_rx);
    rx_if.deser_enable = en;
    rx_if.serial_data  = b;
    @(posedge clk_240m_rx);
    model_step(rst, en, b);
    #1;
    chk("outs",
        {rx_if.rx_data, rx_if.rx_valid, rx_if.deser_lock, rx_if.deser_active,
         rx_if.deser_error, rx_if.sync_err_cnt},
        {m_data, m_valid, m_lock, m_active, m_err, 8'(m_errcnt)});
    if (rx_if.rx_valid) begin
      n_valid++;
      if (!seen_valid) begin
        seen_valid  = 1'b1;
        first_valid = rx_if.rx_data;
      end
    end
    if (rx_if.deser_error) n_err_pulse++;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(1'b1, w[i]);
  endtask

  task automatic send_frame(input logic [15:0] s, input bit rnd);
    send_word(s);
    for (int d = 1; d < FRAME_LEN; d++) begin
      if (rnd) send_word(16'($urandom));
      else     send_word(16'(d));
    end
  endtask

  initial begin
    rx_if.deser_enable = 1'b0;
    rx_if.serial_data  = 1'b0;

    // Reset then disabled idle
    rst = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'($urandom));
    rst = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'b0, 1'($urandom));
    chk("idle_active", rx_if.deser_active, 1'b0);
    chk("idle_errcnt", rx_if.sync_err_cnt, 8'd0);

    // Clean lock
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'($urandom));
    n_valid = 0;
    for (int f = 0; f < 4; f++) send_frame(SYNC, 1'b0);
    send_word(SYNC);
    chk("clean_lock", rx_if.deser_lock, 1'b1);
    chk("clean_first_data", first_valid, 16'h0001);
    chk("clean_valid_cnt", n_valid, 14);
    for (int d = 1; d < FRAME_LEN; d++) send_word(16'(d));

    // False hunt hit ahead of the true framing
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    send_word(16'h1234);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
    send_word(SYNC);
    for (int i = 0; i < 5; i++) send_word(16'h0000);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    for (int f = 0; f < 5; f++) send_frame(SYNC, 1'b0);
    chk("false_hit_relock", rx_if.deser_lock, 1'b1);

    // Single miss
    n_valid = 0; n_err_pulse = 0;
    send_frame(BAD, 1'b0);
    send_frame(SYNC, 1'b0);
    chk("miss_pulses", n_err_pulse, 1);
    chk("miss_errcnt", rx_if.sync_err_cnt, 8'd1);
    chk("miss_lock", rx_if.deser_lock, 1'b1);
    chk("miss_valid_cnt", n_valid, 14);

    // Lock loss and relock
    send_frame(BAD, 1'b0);
    send_frame(BAD, 1'b0);
    chk("loss_lock", rx_if.deser_lock, 1'b0);
    chk("loss_errcnt", rx_if.sync_err_cnt, 8'd3);
    for (int f = 0; f < 4; f++) send_frame(SYNC, 1'b0);
    chk("relock", rx_if.deser_lock, 1'b1);

    // Disable on the cycle a data word completes
    send_word(SYNC);
    for (int d = 1; d <= 4; d++) send_word(16'(d));
    send_bit(1'b0, 1'b1);
    chk("dis_valid", rx_if.rx_valid, 1'b0);
    chk("dis_lock", rx_if.deser_lock, 1'b0);
    chk("dis_active", rx_if.deser_active, 1'b0);
    chk("dis_errcnt", rx_if.sync_err_cnt, 8'd3);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'($urandom));

    // Randomized traffic: random offsets, data, corrupted syncs and disables
    for (int it = 0; it < 6; it++) begin
      int lead;
      lead = int'($urandom_range(1, 20));
      for (int i = 0; i < lead; i++) send_bit(1'b1, 1'($urandom));
      for (int f = 0; f < 5; f++) begin
        logic [15:0] s;
        s = SYNC;
        if ($urandom_range(0, 4) == 0) s = s ^ (16'h1 << $urandom_range(0, 15));
        send_frame(s, 1'b1);
      end
      if ($urandom_range(0, 1) == 1) begin
        int gap;
        gap = int'($urandom_range(1, 3));
        for (int i = 0; i < gap; i++) send_bit(1'b0, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
